// File: rtl/switch_debounce_irq_if.sv
// Switch conditioning bundle: raw pins and interrupt controls in, debounced level and interrupt status out.
interface switch_debounce_irq_if #(
  parameter int unsigned NUM_SW = 16
);
  logic [NUM_SW-1:0] sw_raw_i;
  logic [NUM_SW-1:0] irq_en_i;
  logic [NUM_SW-1:0] irq_clr_i;
  logic [NUM_SW-1:0] sw_o;
  logic [NUM_SW-1:0] irq_pend_o;
  logic              irq_o;

  modport master (
    output sw_raw_i, irq_en_i, irq_clr_i,
    input  sw_o, irq_pend_o, irq_o
  );

  modport slave (
    input  sw_raw_i, irq_en_i, irq_clr_i,
    output sw_o, irq_pend_o, irq_o
  );
endinterface

// File: rtl/switch_debounce_irq.sv
// Per-line 2-FF sync, stable-count debounce and optional edge interrupt for board switches.
// Edge/pending/irq logic is built only when SW_EDGE_IRQ_EN is defined.
module switch_debounce_irq #(
  parameter int unsigned NUM_SW          = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input logic             clk,
  input logic             rst,
  switch_debounce_irq_if.slave bus
);
  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, COUNT} state_t;

  logic [NUM_SW-1:0] s1_q, s2_q, sw_q, sw_d;
  logic [CNT_W-1:0]  cnt_q [NUM_SW];
  logic [CNT_W-1:0]  cnt_d [NUM_SW];
  state_t            state [NUM_SW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      sw_q <= '0;
      for (int unsigned i = 0; i < NUM_SW; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= bus.sw_raw_i;
      s2_q <= s1_q;
      sw_q <= sw_d;
      for (int unsigned i = 0; i < NUM_SW; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // State is implied by s2 vs. the accepted level; any agreeing cycle zeroes the count.
  always_comb begin
    sw_d = sw_q;
    for (int unsigned i = 0; i < NUM_SW; i++) begin
      state[i] = (s2_q[i] != sw_q[i]) ? COUNT : IDLE;
      cnt_d[i] = '0;
      if (state[i] == COUNT) begin
        if (cnt_q[i] == CNT_LAST) sw_d[i] = s2_q[i];
        else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign bus.sw_o = sw_q;

`ifdef SW_EDGE_IRQ_EN
  logic [NUM_SW-1:0] edge_evt, pend_q, pend_d;
  logic              irq_q;

  // Set term is OR'd in last so a same-cycle clear cannot drop a new event.
  always_comb begin
    edge_evt = sw_d ^ sw_q;
    pend_d   = (pend_q & ~bus.irq_clr_i) | (edge_evt & bus.irq_en_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_q  <= |pend_d;
    end
  end

  assign bus.irq_pend_o = pend_q;
  assign bus.irq_o      = irq_q;
`else
  logic unused_irq_ctrl;
  assign unused_irq_ctrl = ^{bus.irq_en_i, bus.irq_clr_i};
  assign bus.irq_pend_o  = '0;
  assign bus.irq_o       = 1'b0;
`endif
endmodule

// File: tb/tb_switch_debounce_irq.sv
// Directed bench for switch_debounce_irq (NUM_SW=4, DEBOUNCE_CYCLES=4); adapts to SW_EDGE_IRQ_EN.
module tb_switch_debounce_irq;
  localparam int unsigned NSW = 4;
  localparam int unsigned DBC = 4;
`ifdef SW_EDGE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  switch_debounce_irq_if #(.NUM_SW(NSW)) bus ();

  switch_debounce_irq #(
    .NUM_SW          (NSW),
    .DEBOUNCE_CYCLES (DBC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected pending/irq when the interrupt feature is built, else zero.
  function automatic logic [31:0] ep(input logic [31:0] v);
    return IRQ_ON ? v : 32'h0;
  endfunction

  initial begin
    bus.sw_raw_i  = 4'hF;
    bus.irq_en_i  = 4'h0;
    bus.irq_clr_i = 4'h0;

    // Reset with all switches high
    tick(3);
    check("rst_sw",   bus.sw_o,       32'h0);
    check("rst_pend", bus.irq_pend_o, 32'h0);
    check("rst_irq",  bus.irq_o,      32'h0);
    rst = 1'b0;
    tick(5);
    check("rel_sw_5", bus.sw_o, 32'h0);
    tick(1);
    check("rel_sw_6", bus.sw_o, 32'hF);

    // Re-reset with switches low, then clean press on line 0
    bus.sw_raw_i = 4'h0;
    rst = 1'b1;
    #1;
    check("rst_async_sw", bus.sw_o, 32'h0);
    tick(1);
    rst = 1'b0;
    tick(10);
    check("idle_sw", bus.sw_o, 32'h0);
    bus.irq_en_i = 4'h1;
    bus.sw_raw_i = 4'h1;
    tick(5);
    check("press_sw_5",   bus.sw_o,       32'h0);
    check("press_pend_5", bus.irq_pend_o, 32'h0);
    tick(1);
    check("press_sw_6",   bus.sw_o,       32'h1);
    check("press_pend_6", bus.irq_pend_o, ep(32'h1));
    check("press_irq_6",  bus.irq_o,      ep(32'h1));

    // Bounce on line 1: three cycles high is rejected
    bus.irq_en_i = 4'h3;
    bus.sw_raw_i = 4'h3;
    tick(3);
    bus.sw_raw_i = 4'h1;
    tick(10);
    check("bounce_sw",   bus.sw_o,       32'h1);
    check("bounce_pend", bus.irq_pend_o, ep(32'h1));

    // Release line 0; clear pulses on the same edge as the new event
    bus.sw_raw_i = 4'h0;
    tick(5);
    check("rel0_sw_5", bus.sw_o, 32'h1);
    bus.irq_clr_i = 4'h1;
    tick(1);
    check("setclr_sw",   bus.sw_o,       32'h0);
    check("setclr_pend", bus.irq_pend_o, ep(32'h1));
    check("setclr_irq",  bus.irq_o,      ep(32'h1));
    tick(1);
    check("clr_pend", bus.irq_pend_o, 32'h0);
    check("clr_irq",  bus.irq_o,      32'h0);
    tick(1);
    check("clr_again_pend", bus.irq_pend_o, 32'h0);
    bus.irq_clr_i = 4'h0;

    // Masked toggles on line 2
    bus.irq_en_i = 4'h0;
    bus.sw_raw_i = 4'h4;
    tick(6);
    check("mask_up_sw",   bus.sw_o,       32'h4);
    check("mask_up_pend", bus.irq_pend_o, 32'h0);
    bus.sw_raw_i = 4'h0;
    tick(6);
    check("mask_dn_sw",   bus.sw_o,       32'h0);
    check("mask_dn_irq",  bus.irq_o,      32'h0);

    // Disabling enable keeps an existing pending bit
    bus.irq_en_i = 4'h8;
    bus.sw_raw_i = 4'h8;
    tick(6);
    check("en3_sw",   bus.sw_o,       32'h8);
    check("en3_pend", bus.irq_pend_o, ep(32'h8));
    bus.irq_en_i = 4'h0;
    tick(3);
    check("en3_hold_pend", bus.irq_pend_o, ep(32'h8));
    check("en3_hold_irq",  bus.irq_o,      ep(32'h1));

    // Reset mid-count clears everything; debounce restarts from zero
    bus.sw_raw_i = 4'hA;
    tick(4);
    rst = 1'b1;
    #1;
    check("midrst_sw",   bus.sw_o,       32'h0);
    check("midrst_pend", bus.irq_pend_o, 32'h0);
    check("midrst_irq",  bus.irq_o,      32'h0);
    tick(1);
    rst = 1'b0;
    tick(5);
    check("midrst_sw_5", bus.sw_o, 32'h0);
    tick(1);
    check("midrst_sw_6",   bus.sw_o,       32'hA);
    check("midrst_pend_6", bus.irq_pend_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
